// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation search controller.
package sar_pkg;

   localparam int SAR_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRIAL = 2'd1,
      ST_DONE  = 2'd2
   } sar_state_t;

endpackage

// File: rtl/sar_search4_if.sv
// Bundle between the search controller and its requester/comparator side.
interface sar_search4_if
   import sar_pkg::*;
#(
   parameter int WIDTH = SAR_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] trial;
   logic             cmp_g;
   logic             cmp_e;
   logic             cmp_s;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             err;

   modport master (
      output start, cmp_g, cmp_e, cmp_s,
      input  trial, busy, done, result, err
   );

   modport slave (
      input  start, cmp_g, cmp_e, cmp_s,
      output trial, busy, done, result, err
   );

endinterface

// File: rtl/sar_cmp_top.sv
// Integration wrapper: search controller paired with a comparator on unknown input a.
module sar_cmp_top
   import sar_pkg::*;
#(
   parameter int WIDTH = SAR_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] trial,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             err
);

   sar_search4_if #(.WIDTH(WIDTH)) bus ();

   assign bus.start = start;

   sar_cmp4 #(.WIDTH(WIDTH)) u_cmp (
      .a (a),
      .b (bus.trial),
      .g (bus.cmp_g),
      .e (bus.cmp_e),
      .s (bus.cmp_s)
   );

   sar_search4 #(.WIDTH(WIDTH)) u_sar (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign trial  = bus.trial;
   assign busy   = bus.busy;
   assign done   = bus.done;
   assign result = bus.result;
   assign err    = bus.err;

endmodule

// File: rtl/sar_search4_cmp.sv
// Combinational magnitude comparator: g = a>b, e = a==b, s = a<b.
module sar_cmp4 #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             g,
   output logic             e,
   output logic             s
);

   assign g = (a > b);
   assign e = (a == b);
   assign s = (a < b);

endmodule

// File: rtl/sar_search4.sv
// MSB-first successive-approximation search driven by an external comparator.
module sar_search4
   import sar_pkg::*;
#(
   parameter int WIDTH = SAR_WIDTH
) (
   input  logic           clk,
   input  logic           rst,
   sar_search4_if.slave   bus
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   sar_state_t       state_reg, state_next;
   logic [IDX_W-1:0] idx_reg, idx_next;
   logic [WIDTH-1:0] acc_reg, acc_next;
   logic [WIDTH-1:0] result_reg, result_next;
   logic             err_reg, err_next;
   logic [WIDTH-1:0] bit_mask;
   logic             one_hot;

   // One-hot decode of the bit currently under trial.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
         assign bit_mask[gi] = (idx_reg == IDX_W'(gi));
      end
   endgenerate

   // Exactly one flag set: odd parity but not all three.
   assign one_hot = (bus.cmp_g ^ bus.cmp_e ^ bus.cmp_s)
                  & ~(bus.cmp_g & bus.cmp_e & bus.cmp_s);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         idx_reg    <= '0;
         acc_reg    <= '0;
         result_reg <= '0;
         err_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         idx_reg    <= idx_next;
         acc_reg    <= acc_next;
         result_reg <= result_next;
         err_reg    <= err_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (bus.start) state_next = ST_TRIAL;
         ST_TRIAL: if (idx_reg == '0) state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      idx_next    = idx_reg;
      acc_next    = acc_reg;
      result_next = result_reg;
      err_next    = err_reg;
      case (state_reg)
         ST_IDLE: begin
            if (bus.start) begin
               idx_next = IDX_W'(WIDTH - 1);
               acc_next = '0;
               err_next = 1'b0;
            end
         end
         ST_TRIAL: begin
            // Keep the trial bit only when a >= trial; decision ignores g/e.
            acc_next = bus.cmp_s ? (acc_reg & ~bit_mask) : (acc_reg | bit_mask);
            if (!one_hot) err_next = 1'b1;
            if (idx_reg != '0) idx_next = idx_reg - IDX_W'(1);
            else               result_next = acc_next;
         end
         default: ;
      endcase
   end

   always_comb begin
      bus.trial = '0;
      bus.busy  = 1'b0;
      bus.done  = 1'b0;
      case (state_reg)
         ST_TRIAL: begin
            bus.trial = acc_reg | bit_mask;
            bus.busy  = 1'b1;
         end
         ST_DONE: bus.done = 1'b1;
         default: ;
      endcase
   end

   assign bus.result = result_reg;
   assign bus.err    = err_reg;

endmodule

// File: tb/tb_sar_search4.sv
// Bench for sar_search4: cycle model plus directed searches, faults and reset abort.
module tb_sar_search4;
   import sar_pkg::*;

   localparam int W = SAR_WIDTH;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         fault = 1'b0;
   logic [W-1:0] a = '0;

   always #5 clk = ~clk;

   sar_search4_if #(.WIDTH(W)) bus ();

   // Bench-side comparator; fault forces g = s = 1 to break one-hotness.
   assign bus.start = start;
   assign bus.cmp_g = fault ? 1'b1 : (a > bus.trial);
   assign bus.cmp_e = fault ? 1'b0 : (a == bus.trial);
   assign bus.cmp_s = fault ? 1'b1 : (a < bus.trial);

   sar_search4 #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [W-1:0] top_trial, top_result;
   logic         top_busy, top_done, top_err;

   sar_cmp_top #(.WIDTH(W)) u_top (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .trial  (top_trial),
      .busy   (top_busy),
      .done   (top_done),
      .result (top_result),
      .err    (top_err)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int done_cnt = 0;
   int tq[$];

   function automatic void check(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Model: phase 0 = idle, 1..W = trial for bit W-phase, W+1 = done.
   int ph = 0;
   int macc = 0;
   int mres = 0;
   bit merr = 1'b0;

   function automatic int mtrial(int p, int acc);
      if (p >= 1 && p <= W) return acc | (1 << (W - p));
      return 0;
   endfunction

   function automatic int mstep(int acc, int p, bit f, int av);
      int t;
      t = acc | (1 << (W - p));
      if (f || (av < t)) return acc;
      return t;
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         ph   <= 0;
         macc <= 0;
         mres <= 0;
         merr <= 1'b0;
      end else if (ph == 0) begin
         if (start) begin
            ph   <= 1;
            macc <= 0;
            merr <= 1'b0;
         end
      end else if (ph <= W) begin
         if (fault) merr <= 1'b1;
         macc <= mstep(macc, ph, fault, int'(a));
         if (ph == W) mres <= mstep(macc, ph, fault, int'(a));
         ph <= ph + 1;
      end else begin
         ph <= 0;
      end
   end

   always @(negedge clk) begin
      if (cyc > 0) begin
         check("busy", int'(bus.busy), int'(ph >= 1 && ph <= W));
         check("done", int'(bus.done), int'(ph == W + 1));
         check("err", int'(bus.err), int'(merr));
         check("busy_done_excl", int'(bus.busy && bus.done), 0);
         if (ph <= W) check("trial", int'(bus.trial), mtrial(ph, macc));
         if (ph == W + 1) check("result", int'(bus.result), mres);
         check("top_busy", int'(top_busy), int'(ph >= 1 && ph <= W));
         check("top_done", int'(top_done), int'(ph == W + 1));
         check("top_err", int'(top_err), 0);
         if (top_done) check("top_result", int'(top_result), int'(a));
         if (bus.busy) tq.push_back(int'(bus.trial));
         if (bus.done) done_cnt++;
      end
   end

   task automatic wait_done(output int lat);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.done) begin
            lat = i;
            break;
         end
      end
      if (lat == 0) check("done_timeout", 0, 1);
   endtask

   task automatic run_one(input logic [W-1:0] av, output int lat, output int res);
      @(posedge clk); #1;
      a = av;
      start = 1'b1;
      tq.delete();
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(lat);
      res = int'(bus.result);
      $display("search a=%0d result=%0d latency=%0d err=%0d", av, res, lat, bus.err);
   endtask

   task automatic check_seq(string name, int e0, int e1, int e2, int e3);
      int exp[4];
      exp = '{e0, e1, e2, e3};
      check({name, "_len"}, tq.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < tq.size()) check(name, tq[i], exp[i]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat, res, d1, d2, d3, r1, r2, r3, dc;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_err", int'(bus.err), 0);
      check("rst_result", int'(bus.result), 0);
      check("rst_trial", int'(bus.trial), 0);

      run_one(4'b1011, lat, res);
      check("b1011_lat", lat, 5);
      check("b1011_res", res, 11);
      check("b1011_err", int'(bus.err), 0);
      check_seq("b1011_trial", 8, 12, 10, 11);

      for (int v = 0; v < 16; v++) begin
         run_one(W'(v), lat, res);
         check("sweep_lat", lat, 5);
         check("sweep_res", res, v);
         if (v == 0)  check_seq("a0_trial", 8, 4, 2, 1);
         if (v == 15) check_seq("a15_trial", 8, 12, 14, 15);
      end

      // Back-to-back searches with start held high.
      @(posedge clk); #1;
      a = 4'd5;
      start = 1'b1;
      wait_done(lat); d1 = cyc; r1 = int'(bus.result);
      @(posedge clk); #1 a = 4'd9;
      wait_done(lat); d2 = cyc; r2 = int'(bus.result);
      @(posedge clk); #1 a = 4'd14;
      wait_done(lat); d3 = cyc; r3 = int'(bus.result);
      @(posedge clk); #1 start = 1'b0;
      $display("back2back results=%0d,%0d,%0d done_cycles=%0d,%0d,%0d", r1, r2, r3, d1, d2, d3);
      check("b2b_res1", r1, 5);
      check("b2b_res2", r2, 9);
      check("b2b_res3", r3, 14);
      check("b2b_gap12", d2 - d1, 6);
      check("b2b_gap23", d3 - d2, 6);

      // Reset during cycle 3 of a search.
      @(posedge clk); #1;
      a = 4'd7;
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      dc = done_cnt;
      @(negedge clk);
      $display("reset abort a=7 busy=%0d result=%0d", bus.busy, bus.result);
      check("abort_busy", int'(bus.busy), 0);
      check("abort_result", int'(bus.result), 0);
      check("abort_trial", int'(bus.trial), 0);
      repeat (8) @(negedge clk);
      check("abort_no_done", done_cnt - dc, 0);

      // Non-one-hot comparator flags during cycle 2.
      @(posedge clk); #1;
      a = 4'd6;
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1 fault = 1'b1;
      @(posedge clk); #1 fault = 1'b0;
      @(negedge clk);
      check("fault_err_c3", int'(bus.err), 1);
      wait_done(lat);
      $display("fault search a=6 result=%0d err=%0d", bus.result, bus.err);
      check("fault_err_done", int'(bus.err), 1);
      check("fault_res", int'(bus.result), 3);
      @(negedge clk);
      check("fault_err_idle", int'(bus.err), 1);
      check("fault_idle_busy", int'(bus.busy), 0);
      @(posedge clk); #1;
      a = 4'd9;
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      check("err_cleared", int'(bus.err), 0);
      wait_done(lat);
      $display("search a=9 result=%0d err=%0d", bus.result, bus.err);
      check("post_fault_res", int'(bus.result), 9);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
